// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store requesters.
// Data has fixed priority over fetch; flushed fetches are withdrawn or dropped.
module mem_port_arbiter #(
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [AWIDTH-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_done,
  output logic [DWIDTH-1:0]   if_rdata,
  output logic                if_busy,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [AWIDTH-1:0]   dm_addr,
  input  logic [DWIDTH-1:0]   dm_wdata,
  input  logic [DWIDTH/8-1:0] dm_be,
  output logic                dm_done,
  output logic [DWIDTH-1:0]   dm_rdata,
  output logic                dm_busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH-1:0]   mem_wdata,
  output logic [DWIDTH/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DWIDTH-1:0]   mem_rdata,
  output logic                owner,
  output logic                timeout_err
);

  localparam int unsigned BEW = DWIDTH / 8;
  localparam int unsigned CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              drop_q, drop_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [BEW-1:0]    be_q, be_d;
  logic              owner_q, owner_d;
  logic              terr_q, terr_d;

  logic              in_req, in_resp, fetch_own;
  logic              withdraw, complete, expire, finish, suppress;
  logic [DWIDTH-1:0] rsp_data;

  // Completion is either a real response or a timeout abort (which returns zero data).
  assign in_req    = (state_q == S_REQ);
  assign in_resp   = (state_q == S_RESP);
  assign fetch_own = ~owner_q;
  assign withdraw  = in_req & fetch_own & if_flush & ~mem_gnt;
  assign complete  = in_resp & mem_rvalid;
  assign expire    = (in_req | in_resp) & (cnt_q == CNT_LAST) & ~complete & ~withdraw;
  assign finish    = complete | expire;
  assign suppress  = fetch_own & (drop_q | if_flush);
  assign rsp_data  = complete ? mem_rdata : '0;

  assign if_done  = finish & fetch_own & ~suppress;
  assign dm_done  = finish & owner_q;
  assign if_rdata = if_done ? rsp_data : '0;
  assign dm_rdata = dm_done ? rsp_data : '0;
  assign if_busy  = if_req & ~if_done;
  assign dm_busy  = dm_req & ~dm_done;

  assign mem_req     = mem_req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign owner       = owner_q;
  assign timeout_err = terr_q;

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    owner_d   = owner_q;
    terr_d    = terr_q | expire;
    mem_req_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (dm_req) begin
          state_d = S_REQ;
          cnt_d   = '0;
          we_d    = dm_we;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          be_d    = dm_be;
          owner_d = 1'b1;
        end else if (if_req && !if_flush) begin
          state_d = S_REQ;
          cnt_d   = '0;
          we_d    = 1'b0;
          addr_d  = if_addr;
          wdata_d = '0;
          be_d    = '1;
          owner_d = 1'b0;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (withdraw || expire) begin
          state_d = S_IDLE;
        end else if (mem_gnt) begin
          state_d = S_RESP;
          // A flush coinciding with the grant still cancels the fetch.
          if (fetch_own && if_flush) drop_d = 1'b1;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + CW'(1);
        if (fetch_own && if_flush) drop_d = 1'b1;
        if (finish) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      drop_q    <= 1'b0;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      owner_q   <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      mem_req_q <= mem_req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      owner_q   <= owner_d;
      terr_q    <= terr_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner cases,
// and randomized transactions scored against a transaction-level expectation queue.
module tb_mem_port_arbiter;

  logic        clk, reset;
  logic        if_req, if_flush, if_done, if_busy;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_done, dm_busy;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, owner, timeout_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata), .if_busy(if_busy),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_busy(dm_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .owner(owner), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next cycle and clear single-cycle stimulus.
  task automatic nxt();
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if_flush   = 1'b0;
  endtask

  typedef struct {
    logic dm_req; logic dm_we; logic [31:0] dm_addr; logic [31:0] dm_wdata;
    logic if_req; logic [31:0] if_addr; logic if_flush;
    logic gnt; logic rvalid; logic [31:0] rdata;
    logic e_mreq; logic e_we; logic [31:0] e_addr; logic e_owner;
    logic e_dmd; logic e_ifd; logic chk_rd; logic [31:0] e_rd;
    logic e_dmb; logic e_ifb;
  } vec_t;

  typedef struct {
    logic is_dm; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;
  } txn_t;

  vec_t tbl[12];
  txn_t q[$];
  txn_t t, cur;
  int   sel, cyc, mph, mph0, gd, rd;
  logic idle_prev, fresh, dm_fin, if_fin, e_mreq, e_dmd, e_ifd, abort;

  initial begin
    // Single load, then data/fetch contention (store first, fetch after one IDLE).
    tbl[0]  = '{1,0,32'h100,0,          0,0,0,     0,0,0,            0,0,32'h0,0,   0,0,0,0,            1,0};
    tbl[1]  = '{1,0,32'h100,0,          0,0,0,     1,0,0,            1,0,32'h100,1, 0,0,0,0,            1,0};
    tbl[2]  = '{1,0,32'h100,0,          0,0,0,     0,1,32'hDEADBEEF, 0,0,32'h100,1, 1,0,1,32'hDEADBEEF, 0,0};
    tbl[3]  = '{0,0,32'h100,0,          0,0,0,     0,0,0,            0,0,32'h100,1, 0,0,0,0,            0,0};
    tbl[4]  = '{1,1,32'h200,32'h12345678, 1,32'h40,0, 0,0,0,         0,0,32'h100,1, 0,0,0,0,            1,1};
    tbl[5]  = '{1,1,32'h200,32'h12345678, 1,32'h40,0, 0,0,0,         1,1,32'h200,1, 0,0,0,0,            1,1};
    tbl[6]  = '{1,1,32'h200,32'h12345678, 1,32'h40,0, 1,0,0,         1,1,32'h200,1, 0,0,0,0,            1,1};
    tbl[7]  = '{1,1,32'h200,32'h12345678, 1,32'h40,0, 0,1,32'hAAAA5555, 0,1,32'h200,1, 1,0,0,0,         0,1};
    tbl[8]  = '{0,0,32'h200,0,          1,32'h40,0, 0,0,0,           0,1,32'h200,1, 0,0,0,0,            0,1};
    tbl[9]  = '{0,0,32'h200,0,          1,32'h40,0, 1,0,0,           1,0,32'h40,0,  0,0,0,0,            0,1};
    tbl[10] = '{0,0,32'h200,0,          1,32'h40,0, 0,1,32'h0BADF00D, 0,0,32'h40,0, 0,1,1,32'h0BADF00D, 0,0};
    tbl[11] = '{0,0,32'h200,0,          0,32'h40,0, 0,0,0,           0,0,32'h40,0,  0,0,0,0,            0,0};

    reset = 1'b1;
    if_req = 0; if_addr = 0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 4'hF;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    abort = 0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_owner", owner, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_dones", {if_done, dm_done}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      nxt();
      dm_req = tbl[i].dm_req; dm_we = tbl[i].dm_we; dm_addr = tbl[i].dm_addr; dm_wdata = tbl[i].dm_wdata;
      if_req = tbl[i].if_req; if_addr = tbl[i].if_addr; if_flush = tbl[i].if_flush;
      mem_gnt = tbl[i].gnt; mem_rvalid = tbl[i].rvalid; mem_rdata = tbl[i].rdata;
      #2;
      chk($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].e_mreq);
      chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_owner", i), owner, tbl[i].e_owner);
      chk($sformatf("tbl%0d_dm_done", i), dm_done, tbl[i].e_dmd);
      chk($sformatf("tbl%0d_if_done", i), if_done, tbl[i].e_ifd);
      chk($sformatf("tbl%0d_dm_busy", i), dm_busy, tbl[i].e_dmb);
      chk($sformatf("tbl%0d_if_busy", i), if_busy, tbl[i].e_ifb);
      if (tbl[i].chk_rd && tbl[i].e_dmd) chk($sformatf("tbl%0d_dm_rdata", i), dm_rdata, tbl[i].e_rd);
      if (tbl[i].chk_rd && tbl[i].e_ifd) chk($sformatf("tbl%0d_if_rdata", i), if_rdata, tbl[i].e_rd);
    end

    // Flush while the fetch waits for grant: request withdrawn, no done.
    nxt(); if_req = 1; if_addr = 32'h40; #2;
    nxt(); #2;
    chk("flreq_mem_req_up", mem_req, 1);
    chk("flreq_addr", mem_addr, 32'h40);
    nxt(); if_flush = 1; #2;
    chk("flreq_no_done", if_done, 0);
    nxt(); if_req = 0; #2;
    chk("flreq_mem_req_drop", mem_req, 0);
    chk("flreq_no_done_after", if_done, 0);
    nxt(); #2;
    chk("flreq_idle", mem_req, 0);

    // Flush after grant: response dropped, next fetch served normally.
    nxt(); if_req = 1; if_addr = 32'h40; #2;
    nxt(); mem_gnt = 1; #2;
    chk("flresp_mem_req", mem_req, 1);
    nxt(); if_flush = 1; #2;
    chk("flresp_no_done0", if_done, 0);
    nxt(); if_addr = 32'h80; #2;
    nxt(); mem_rvalid = 1; mem_rdata = 32'h11111111; #2;
    chk("flresp_dropped", if_done, 0);
    chk("flresp_busy", if_busy, 1);
    nxt(); #2;
    chk("flresp_idle", mem_req, 0);
    nxt(); mem_gnt = 1; #2;
    chk("flresp_next_req", mem_req, 1);
    chk("flresp_next_addr", mem_addr, 32'h80);
    chk("flresp_next_owner", owner, 0);
    nxt(); mem_rvalid = 1; mem_rdata = 32'h22222222; #2;
    chk("flresp_next_done", if_done, 1);
    chk("flresp_next_rdata", if_rdata, 32'h22222222);
    nxt(); if_req = 0; #2;
    chk("flresp_quiet", if_done, 0);

    // Timeout: grant never comes; abort with zero data on the 8th REQ cycle.
    nxt(); dm_req = 1; dm_we = 0; dm_addr = 32'h300; dm_be = 4'hF; mem_rdata = 32'hFFFFFFFF; #2;
    chk("tmo_err_before", timeout_err, 0);
    for (int k = 1; k <= 8; k++) begin
      nxt(); #2;
      chk($sformatf("tmo_c%0d_mem_req", k), mem_req, 1);
      chk($sformatf("tmo_c%0d_dm_done", k), dm_done, (k == 8) ? 1 : 0);
      if (k == 8) chk("tmo_rdata_zero", dm_rdata, 0);
    end
    nxt(); dm_req = 0; mem_rvalid = 1; #2;
    chk("tmo_err_set", timeout_err, 1);
    chk("tmo_idle_rvalid_ignored", dm_done, 0);
    chk("tmo_idle_mem_req", mem_req, 0);
    nxt(); dm_req = 1; dm_addr = 32'h304; #2;
    nxt(); mem_gnt = 1; #2;
    nxt(); mem_rvalid = 1; mem_rdata = 32'hCAFEF00D; #2;
    chk("tmo_good_done", dm_done, 1);
    chk("tmo_good_rdata", dm_rdata, 32'hCAFEF00D);
    nxt(); dm_req = 0; #2;
    chk("tmo_err_sticky", timeout_err, 1);

    // Randomized episodes: expected completion order and data come from the queue.
    for (int ep = 0; ep < 40 && !abort; ep++) begin
      sel = $urandom_range(1, 3);
      nxt();
      q.delete();
      if ((sel & 1) != 0) begin
        t.is_dm = 1; t.we = 1'($urandom_range(0, 1)); t.addr = $urandom; t.wdata = $urandom;
        t.be = 4'($urandom_range(1, 15));
        q.push_back(t);
        dm_req = 1; dm_we = t.we; dm_addr = t.addr; dm_wdata = t.wdata; dm_be = t.be;
      end
      if ((sel & 2) != 0) begin
        t.is_dm = 0; t.we = 0; t.addr = $urandom; t.wdata = 0; t.be = 4'hF;
        q.push_back(t);
        if_req = 1; if_addr = t.addr;
      end
      mph = 0; idle_prev = 0; cyc = 0;
      while (1) begin
        mph0 = mph;
        e_mreq = (mph == 1) ? 1'b1 : ((mph == 0) ? idle_prev : 1'b0);
        fresh = 0; e_dmd = 0; e_ifd = 0;
        if (mph == 0 && e_mreq) begin
          cur = q[0]; mph = 1; gd = $urandom_range(0, 3); fresh = 1;
        end
        if (mph == 1) begin
          if (gd == 0) begin mem_gnt = 1; mph = 2; rd = $urandom_range(1, 3); end
          else gd--;
        end else if (mph == 2) begin
          rd--;
          if (rd == 0) begin
            mem_rvalid = 1; mem_rdata = $urandom; mph = 0;
            if (cur.is_dm) e_dmd = 1; else e_ifd = 1;
            void'(q.pop_front());
          end
        end
        #2;
        chk("rnd_mem_req", mem_req, e_mreq);
        if (fresh) begin
          chk("rnd_owner", owner, cur.is_dm);
          chk("rnd_we", mem_we, cur.we);
          chk("rnd_addr", mem_addr, cur.addr);
          chk("rnd_be", mem_be, cur.be);
          if (cur.we) chk("rnd_wdata", mem_wdata, cur.wdata);
        end
        chk("rnd_dm_done", dm_done, e_dmd);
        chk("rnd_if_done", if_done, e_ifd);
        if (e_dmd && !cur.we) chk("rnd_dm_rdata", dm_rdata, mem_rdata);
        if (e_ifd) chk("rnd_if_rdata", if_rdata, mem_rdata);
        chk("rnd_dm_busy", dm_busy, dm_req & ~e_dmd);
        chk("rnd_if_busy", if_busy, if_req & ~e_ifd);
        idle_prev = (mph0 == 0) && !e_mreq && (q.size() > 0);
        dm_fin = e_dmd; if_fin = e_ifd;
        if (q.size() == 0 && mph == 0 && !dm_req && !if_req) break;
        cyc++;
        if (cyc > 40) begin
          n_chk++; n_fail++;
          $display("FAIL rnd_bound: episode %0d exceeded %0d cycles", ep, cyc);
          abort = 1;
          break;
        end
        nxt();
        if (dm_fin) dm_req = 0;
        if (if_fin) if_req = 0;
      end
      chk("rnd_terr_sticky", timeout_err, 1);
    end
    dm_req = 0; if_req = 0;

    // Reset while waiting for the response; a late rvalid must be ignored.
    nxt(); if_req = 1; if_addr = 32'h44; #2;
    nxt(); mem_gnt = 1; #2;
    nxt(); #2;
    reset = 1;
    nxt(); if_req = 0;
    nxt(); reset = 0; #2;
    nxt(); mem_rvalid = 1; mem_rdata = 32'h5555AAAA; #2;
    chk("rstm_if_done", if_done, 0);
    chk("rstm_dm_done", dm_done, 0);
    chk("rstm_mem_req", mem_req, 0);
    chk("rstm_owner", owner, 0);
    chk("rstm_timeout_err", timeout_err, 0);
    chk("rstm_mem_fields", {mem_we, mem_addr, mem_be}, 0);
    chk("rstm_mem_wdata", mem_wdata, 0);
    chk("rstm_rdata", {if_rdata, dm_rdata}, 0);
    chk("rstm_busy", {if_busy, dm_busy}, 0);
    nxt(); #2;
    chk("rstm_still_idle", mem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
